mux_operand_sequencer: RTL

- Upstream stage for the 4-bit 2:1 mux datapath. Holds two loadable operand registers that drive the mux data inputs i0/i1, and generates the mux select s.
- A start command runs a timed, alternating select sequence (s=0 then s=1, repeated ROUNDS times), then pulses done.
- Operands are loaded through a valid/ready port while the block is idle.

---
 rtl/mux_operand_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mux_operand_sequencer.sv
// Operand/select sequencer feeding a WIDTH-bit 2:1 mux: loadable i0/i1 plus a timed s=0/s=1 sequence.
// Optional MUX_SEQ_AUTOINC_EN: bump both operands at the end of every SEL1 hold.
module mux_operand_sequencer #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int ROUNDS      = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             load_sel_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] i0_o,
  output logic [WIDTH-1:0] i1_o,
  output logic             s_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] ROUNDS_V  = RW'(ROUNDS);

  typedef enum logic [1:0] {IDLE, SEL0, SEL1, DONE} state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [RW-1:0]    round_q, round_d, round_inc;
  logic [WIDTH-1:0] i0_q, i0_d, i1_q, i1_d;
  logic             hold_end;

  assign hold_end  = (hold_q == HOLD_LAST);
  assign round_inc = round_q + RW'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hold_q  <= '0;
      round_q <= '0;
      i0_q    <= '0;
      i1_q    <= '0;
    end else begin
      hold_q  <= hold_d;
      round_q <= round_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    round_d = round_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    case (state_q)
      IDLE: begin
        // load and start may share an edge; SEL0 then sees the new operand
        if (load_valid_i) begin
          if (load_sel_i) i1_d = load_data_i;
          else            i0_d = load_data_i;
        end
        if (start_i) begin
          state_d = SEL0;
          hold_d  = '0;
          round_d = '0;
        end
      end
      SEL0: begin
        if (hold_end) begin
          state_d = SEL1;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      SEL1: begin
        if (hold_end) begin
          hold_d  = '0;
          round_d = round_inc;
          state_d = (round_inc == ROUNDS_V) ? DONE : SEL0;
`ifdef MUX_SEQ_AUTOINC_EN
          i0_d = i0_q + WIDTH'(1);
          i1_d = i1_q + WIDTH'(1);
`endif
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        hold_d  = '0;
        round_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // abort wins over everything outside IDLE and leaves operands untouched
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      hold_d  = '0;
      round_d = '0;
      i0_d    = i0_q;
      i1_d    = i1_q;
    end
  end

  always_comb begin
    load_ready_o = (state_q == IDLE);
    s_o          = (state_q == SEL1);
    busy_o       = (state_q == SEL0) || (state_q == SEL1);
    done_o       = (state_q == DONE);
  end

  assign i0_o = i0_q;
  assign i1_o = i1_q;

endmodule
